// File: rtl/sparse_chunk_pkg.sv
// Shared types and sizing helpers for the sparse-chunk write stream (sender, receiver, decompressor).
package sparse_chunk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BUS_SIZE_DEF       = 32;
  localparam int WR_DAT_CYC_NUM_DEF = 4;
  localparam int CHUNK_SIZE         = BUS_SIZE_DEF * WR_DAT_CYC_NUM_DEF;
  localparam int NZ_CNT_W           = $clog2(CHUNK_SIZE + 1);
  localparam int BEAT_W             = $clog2(WR_DAT_CYC_NUM_DEF);

endpackage

// File: rtl/sparse_popcount.sv
// Combinational population count of one sparsemap beat.
module sparse_popcount #(
  parameter int W = 32
) (
  input  logic [W-1:0]             bits_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/sparse_chunk_wr_rx.sv
// Sparse-chunk write-stream receiver: sequence-checks beats into a local chunk store,
// tracks per-chunk nonzero counts and valid flags, and serves registered beat reads.
module sparse_chunk_wr_rx
  import sparse_chunk_pkg::*;
#(
  parameter int BUS_SIZE       = 32,
  parameter int DAT_SIZE       = 8,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int CHUNK_NUM      = 16,
  localparam int BW   = idx_w(WR_DAT_CYC_NUM),
  localparam int CW   = idx_w(CHUNK_NUM),
  localparam int DW   = BUS_SIZE * DAT_SIZE,
  localparam int NZ_W = $clog2(BUS_SIZE * WR_DAT_CYC_NUM + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [BUS_SIZE-1:0]  wr_sparsemap_i,
  input  logic [DW-1:0]        wr_nonzero_data_i,
  input  logic                 wr_valid_i,
  input  logic [BW-1:0]        wr_dat_count_i,
  input  logic [CW-1:0]        wr_chunk_count_i,
  output logic                 chunk_done_o,
  output logic [CW-1:0]        chunk_done_idx_o,
  output logic                 seq_err_o,
  output logic [CHUNK_NUM-1:0] chunk_valid_o,
  input  logic                 rd_en_i,
  input  logic [CW-1:0]        rd_chunk_idx_i,
  input  logic [BW-1:0]        rd_beat_idx_i,
  output logic                 rd_valid_o,
  output logic                 rd_hit_o,
  output logic [BUS_SIZE-1:0]  rd_sparsemap_o,
  output logic [DW-1:0]        rd_nonzero_data_o,
  output logic [NZ_W-1:0]      rd_nz_count_o
);

  localparam int DEPTH = CHUNK_NUM * WR_DAT_CYC_NUM;
  localparam int PC_W  = $clog2(BUS_SIZE + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WR_DAT_CYC_NUM - 1);

  logic [BUS_SIZE-1:0] smap_mem [DEPTH];
  logic [DW-1:0]       data_mem [DEPTH];
  logic [NZ_W-1:0]     nz_mem   [CHUNK_NUM];

  rx_state_e            state_q, state_d;
  logic [BW-1:0]        exp_q, exp_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [NZ_W-1:0]      acc_q, acc_d, acc_sum;
  logic [CHUNK_NUM-1:0] chunk_valid_q, chunk_valid_d;
  logic                 done_q, done_d, err_q, err_d;
  logic [CW-1:0]        done_idx_q, done_idx_d;
  logic                 mem_we, nz_we, is_start;
  logic [NZ_W-1:0]      nz_wdata;
  logic [CW-1:0]        nz_widx;
  logic [PC_W-1:0]      pc;

  logic                 rd_valid_q, rd_valid_d, rd_hit_q, rd_hit_d;
  logic [BUS_SIZE-1:0]  rd_smap_q, rd_smap_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic [NZ_W-1:0]      rd_nz_q, rd_nz_d;

  sparse_popcount #(.W(BUS_SIZE)) u_popcount (
    .bits_i (wr_sparsemap_i),
    .cnt_o  (pc)
  );

  assign is_start = (wr_dat_count_i == '0) &&
                    ({1'b0, wr_chunk_count_i} < (CW + 1)'(CHUNK_NUM));
  assign acc_sum  = acc_q + NZ_W'(pc);

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    chunk_valid_d = chunk_valid_q;
    done_d        = 1'b0;
    done_idx_d    = done_idx_q;
    err_d         = 1'b0;
    mem_we        = 1'b0;
    nz_we         = 1'b0;
    nz_wdata      = acc_sum;
    nz_widx       = idx_q;
    if (clear_i) begin
      chunk_valid_d = '0;
      state_d       = IDLE;
    end else if (wr_valid_i) begin
      if (state_q == RECV && wr_dat_count_i == exp_q && wr_chunk_count_i == idx_q) begin
        mem_we = 1'b1;
        acc_d  = acc_sum;
        if (exp_q == LAST_BEAT) begin
          nz_we                  = 1'b1;
          chunk_valid_d[idx_q]   = 1'b1;
          done_d                 = 1'b1;
          done_idx_d             = idx_q;
          state_d                = IDLE;
        end else begin
          exp_d = exp_q + BW'(1);
        end
      end else begin
        // A mismatch in RECV abandons the chunk; a legal start beat still begins a new one.
        err_d = (state_q == RECV) || !is_start;
        if (is_start) begin
          mem_we                          = 1'b1;
          chunk_valid_d[wr_chunk_count_i] = 1'b0;
          idx_d                           = wr_chunk_count_i;
          acc_d                           = NZ_W'(pc);
          exp_d                           = BW'(1);
          if (WR_DAT_CYC_NUM == 1) begin
            nz_we                           = 1'b1;
            nz_wdata                        = NZ_W'(pc);
            nz_widx                         = wr_chunk_count_i;
            chunk_valid_d[wr_chunk_count_i] = 1'b1;
            done_d                          = 1'b1;
            done_idx_d                      = wr_chunk_count_i;
            state_d                         = IDLE;
          end else begin
            state_d = RECV;
          end
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_comb begin
    rd_valid_d = rd_en_i;
    rd_hit_d   = rd_hit_q;
    rd_smap_d  = rd_smap_q;
    rd_data_d  = rd_data_q;
    rd_nz_d    = rd_nz_q;
    if (rd_en_i) begin
      rd_hit_d  = chunk_valid_q[rd_chunk_idx_i];
      rd_smap_d = smap_mem[{rd_chunk_idx_i, rd_beat_idx_i}];
      rd_data_d = data_mem[{rd_chunk_idx_i, rd_beat_idx_i}];
      rd_nz_d   = nz_mem[rd_chunk_idx_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      exp_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      chunk_valid_q <= '0;
      done_q        <= 1'b0;
      done_idx_q    <= '0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_hit_q      <= 1'b0;
      rd_smap_q     <= '0;
      rd_data_q     <= '0;
      rd_nz_q       <= '0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      chunk_valid_q <= chunk_valid_d;
      done_q        <= done_d;
      done_idx_q    <= done_idx_d;
      err_q         <= err_d;
      rd_valid_q    <= rd_valid_d;
      rd_hit_q      <= rd_hit_d;
      rd_smap_q     <= rd_smap_d;
      rd_data_q     <= rd_data_d;
      rd_nz_q       <= rd_nz_d;
    end
  end

  // Storage is not reset so it maps onto a plain dual-port RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      smap_mem[{wr_chunk_count_i, wr_dat_count_i}] <= wr_sparsemap_i;
      data_mem[{wr_chunk_count_i, wr_dat_count_i}] <= wr_nonzero_data_i;
    end
    if (nz_we) begin
      nz_mem[nz_widx] <= nz_wdata;
    end
  end

  assign chunk_done_o      = done_q;
  assign chunk_done_idx_o  = done_idx_q;
  assign seq_err_o         = err_q;
  assign chunk_valid_o     = chunk_valid_q;
  assign rd_valid_o        = rd_valid_q;
  assign rd_hit_o          = rd_hit_q;
  assign rd_sparsemap_o    = rd_smap_q;
  assign rd_nonzero_data_o = rd_data_q;
  assign rd_nz_count_o     = rd_nz_q;

endmodule

// File: tb/tb_sparse_chunk_wr_rx.sv
// Directed self-checking bench for sparse_chunk_wr_rx with default parameters.
module tb_sparse_chunk_wr_rx;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clear_i;
  logic [31:0]  wr_sparsemap_i;
  logic [255:0] wr_nonzero_data_i;
  logic         wr_valid_i;
  logic [1:0]   wr_dat_count_i;
  logic [3:0]   wr_chunk_count_i;
  logic         chunk_done_o;
  logic [3:0]   chunk_done_idx_o;
  logic         seq_err_o;
  logic [15:0]  chunk_valid_o;
  logic         rd_en_i;
  logic [3:0]   rd_chunk_idx_i;
  logic [1:0]   rd_beat_idx_i;
  logic         rd_valid_o;
  logic         rd_hit_o;
  logic [31:0]  rd_sparsemap_o;
  logic [255:0] rd_nonzero_data_o;
  logic [7:0]   rd_nz_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]  m_smap [16][4];
  logic [255:0] m_data [16][4];

  sparse_chunk_wr_rx dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .clear_i           (clear_i),
    .wr_sparsemap_i    (wr_sparsemap_i),
    .wr_nonzero_data_i (wr_nonzero_data_i),
    .wr_valid_i        (wr_valid_i),
    .wr_dat_count_i    (wr_dat_count_i),
    .wr_chunk_count_i  (wr_chunk_count_i),
    .chunk_done_o      (chunk_done_o),
    .chunk_done_idx_o  (chunk_done_idx_o),
    .seq_err_o         (seq_err_o),
    .chunk_valid_o     (chunk_valid_o),
    .rd_en_i           (rd_en_i),
    .rd_chunk_idx_i    (rd_chunk_idx_i),
    .rd_beat_idx_i     (rd_beat_idx_i),
    .rd_valid_o        (rd_valid_o),
    .rd_hit_o          (rd_hit_o),
    .rd_sparsemap_o    (rd_sparsemap_o),
    .rd_nonzero_data_o (rd_nonzero_data_o),
    .rd_nz_count_o     (rd_nz_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input logic [3:0] c, input logic [1:0] b, input logic [7:0] salt);
    return {8{4'hA, c, 6'd0, b, salt, 8'h5C}};
  endfunction

  // Drive one beat, record it in the model, and advance one clock.
  task automatic beat(input logic [1:0] d, input logic [3:0] c, input logic [31:0] s, input logic [7:0] salt);
    wr_valid_i        = 1'b1;
    wr_dat_count_i    = d;
    wr_chunk_count_i  = c;
    wr_sparsemap_i    = s;
    wr_nonzero_data_i = mkdata(c, d, salt);
    m_smap[c][d]      = s;
    m_data[c][d]      = mkdata(c, d, salt);
    tick();
  endtask

  task automatic idle();
    wr_valid_i = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [3:0] c, input logic [1:0] b);
    rd_en_i        = 1'b1;
    rd_chunk_idx_i = c;
    rd_beat_idx_i  = b;
    tick();
    rd_en_i        = 1'b0;
  endtask

  initial begin
    int dones;
    int nz;
    logic [31:0] s;
    logic [3:0]  rc;
    logic [1:0]  rb;

    rst_i = 1'b0; clear_i = 1'b0; wr_valid_i = 1'b0; wr_dat_count_i = '0;
    wr_chunk_count_i = '0; wr_sparsemap_i = '0; wr_nonzero_data_i = '0;
    rd_en_i = 1'b0; rd_chunk_idx_i = '0; rd_beat_idx_i = '0;
    tick(); tick();
    chk("rst_valid", 256'(chunk_valid_o), 256'(16'h0));
    chk("rst_done", 256'(chunk_done_o), 256'(0));
    chk("rst_err", 256'(seq_err_o), 256'(0));
    chk("rst_rd_valid", 256'(rd_valid_o), 256'(0));
    chk("rst_rd_smap", 256'(rd_sparsemap_o), 256'(0));
    chk("rst_rd_nz", 256'(rd_nz_count_o), 256'(0));
    rst_i = 1'b1;
    tick();

    // Test 1: complete chunk 3, nonzero count 32+4+0+2 = 38.
    beat(2'd0, 4'd3, 32'hFFFF_FFFF, 8'h11);
    chk("t1_no_done_b0", 256'(chunk_done_o), 256'(0));
    beat(2'd1, 4'd3, 32'h0000_000F, 8'h11);
    beat(2'd2, 4'd3, 32'h0000_0000, 8'h11);
    beat(2'd3, 4'd3, 32'h8000_0001, 8'h11);
    chk("t1_done", 256'(chunk_done_o), 256'(1));
    chk("t1_done_idx", 256'(chunk_done_idx_o), 256'(3));
    chk("t1_valid", 256'(chunk_valid_o), 256'(16'h0008));
    wr_valid_i = 1'b0;
    rd(4'd3, 2'd1);
    chk("t1_rd_valid", 256'(rd_valid_o), 256'(1));
    chk("t1_rd_smap", 256'(rd_sparsemap_o), 256'(32'h0000_000F));
    chk("t1_rd_data", rd_nonzero_data_o, mkdata(4'd3, 2'd1, 8'h11));
    chk("t1_rd_nz", 256'(rd_nz_count_o), 256'(38));
    chk("t1_rd_hit", 256'(rd_hit_o), 256'(1));
    tick();
    chk("t1_rd_valid_off", 256'(rd_valid_o), 256'(0));
    chk("t1_rd_hold", 256'(rd_sparsemap_o), 256'(32'h0000_000F));

    // Test 2: beats 0,1,3 to chunk 5.
    beat(2'd0, 4'd5, 32'h1, 8'h22);
    chk("t2_err_b0", 256'(seq_err_o), 256'(0));
    beat(2'd1, 4'd5, 32'h3, 8'h22);
    beat(2'd3, 4'd5, 32'h7, 8'h22);
    chk("t2_err", 256'(seq_err_o), 256'(1));
    chk("t2_no_done", 256'(chunk_done_o), 256'(0));
    idle();
    chk("t2_err_pulse", 256'(seq_err_o), 256'(0));
    chk("t2_valid", 256'(chunk_valid_o), 256'(16'h0008));

    // Test 3: chunk 2 abandoned by a fresh start on chunk 7.
    beat(2'd0, 4'd2, 32'hF0, 8'h33);
    beat(2'd1, 4'd2, 32'hF0, 8'h33);
    beat(2'd0, 4'd7, 32'h0F, 8'h33);
    chk("t3_err", 256'(seq_err_o), 256'(1));
    beat(2'd1, 4'd7, 32'h0F, 8'h33);
    chk("t3_err_once", 256'(seq_err_o), 256'(0));
    beat(2'd2, 4'd7, 32'h0F, 8'h33);
    beat(2'd3, 4'd7, 32'h0F, 8'h33);
    chk("t3_done", 256'(chunk_done_o), 256'(1));
    chk("t3_done_idx", 256'(chunk_done_idx_o), 256'(7));
    idle();
    chk("t3_valid", 256'(chunk_valid_o), 256'(16'h0088));

    // Test 4: 16 back-to-back chunks with random sparsemaps.
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      for (int b = 0; b < 4; b++) begin
        s = $urandom;
        beat(2'(b), 4'(c), s, 8'(c * 4 + b));
        if (chunk_done_o === 1'b1) dones++;
      end
    end
    chk("t4_last_idx", 256'(chunk_done_idx_o), 256'(15));
    chk("t4_dones", 256'(dones), 256'(16));
    idle();
    chk("t4_valid", 256'(chunk_valid_o), 256'(16'hFFFF));
    for (int k = 0; k < 8; k++) begin
      rc = 4'($urandom_range(0, 15));
      rb = 2'($urandom_range(0, 3));
      rd(rc, rb);
      nz = $countones(m_smap[rc][0]) + $countones(m_smap[rc][1]) +
           $countones(m_smap[rc][2]) + $countones(m_smap[rc][3]);
      chk("t4_rd_smap", 256'(rd_sparsemap_o), 256'(m_smap[rc][rb]));
      chk("t4_rd_data", rd_nonzero_data_o, m_data[rc][rb]);
      chk("t4_rd_nz", 256'(rd_nz_count_o), 256'(nz));
      chk("t4_rd_hit", 256'(rd_hit_o), 256'(1));
    end

    // Test 5: rewrite chunk 3 while reading its beat 0 in the start cycle.
    s = m_smap[3][0];
    rd_en_i = 1'b1; rd_chunk_idx_i = 4'd3; rd_beat_idx_i = 2'd0;
    beat(2'd0, 4'd3, 32'h0000_00FF, 8'h55);
    rd_en_i = 1'b0;
    chk("t5_rd_old", 256'(rd_sparsemap_o), 256'(s));
    chk("t5_rd_hit", 256'(rd_hit_o), 256'(1));
    chk("t5_valid_cleared", 256'(chunk_valid_o[3]), 256'(0));
    beat(2'd1, 4'd3, 32'h0000_0F00, 8'h55);
    beat(2'd2, 4'd3, 32'h0000_0000, 8'h55);
    chk("t5_valid_pending", 256'(chunk_valid_o[3]), 256'(0));
    beat(2'd3, 4'd3, 32'h0000_0001, 8'h55);
    chk("t5_done_idx", 256'(chunk_done_idx_o), 256'(3));
    chk("t5_valid_set", 256'(chunk_valid_o[3]), 256'(1));
    wr_valid_i = 1'b0;
    rd(4'd3, 2'd0);
    chk("t5_rd_new", 256'(rd_sparsemap_o), 256'(32'h0000_00FF));
    chk("t5_rd_nz", 256'(rd_nz_count_o), 256'(13));

    // Test 6: async reset mid-chunk, then clear_i with a beat.
    beat(2'd0, 4'd9, 32'h1, 8'h66);
    beat(2'd1, 4'd9, 32'h1, 8'h66);
    beat(2'd2, 4'd9, 32'h1, 8'h66);
    wr_valid_i = 1'b0;
    rst_i = 1'b0;
    #2;
    chk("t6_rst_valid", 256'(chunk_valid_o), 256'(16'h0));
    chk("t6_rst_rd_valid", 256'(rd_valid_o), 256'(0));
    tick();
    rst_i = 1'b1;
    tick();
    beat(2'd0, 4'd1, 32'h3, 8'h77);
    beat(2'd1, 4'd1, 32'h3, 8'h77);
    beat(2'd2, 4'd1, 32'h3, 8'h77);
    beat(2'd3, 4'd1, 32'h3, 8'h77);
    chk("t6_pre_clear_valid", 256'(chunk_valid_o), 256'(16'h0002));
    beat(2'd0, 4'd4, 32'h1, 8'h88);
    beat(2'd1, 4'd4, 32'h1, 8'h88);
    clear_i = 1'b1;
    beat(2'd3, 4'd4, 32'h1, 8'h88);
    clear_i = 1'b0;
    chk("t6_clr_err", 256'(seq_err_o), 256'(0));
    chk("t6_clr_done", 256'(chunk_done_o), 256'(0));
    chk("t6_clr_valid", 256'(chunk_valid_o), 256'(16'h0));
    beat(2'd1, 4'd4, 32'h1, 8'h88);
    chk("t6_idle_err", 256'(seq_err_o), 256'(1));
    beat(2'd0, 4'd4, 32'h1, 8'h99);
    beat(2'd1, 4'd4, 32'h2, 8'h99);
    beat(2'd2, 4'd4, 32'h4, 8'h99);
    beat(2'd3, 4'd4, 32'h8, 8'h99);
    chk("t6_done", 256'(chunk_done_o), 256'(1));
    chk("t6_done_idx", 256'(chunk_done_idx_o), 256'(4));
    chk("t6_valid", 256'(chunk_valid_o), 256'(16'h0010));
    wr_valid_i = 1'b0;
    rd(4'd4, 2'd2);
    chk("t6_rd_smap", 256'(rd_sparsemap_o), 256'(32'h4));
    chk("t6_rd_nz", 256'(rd_nz_count_o), 256'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
